// File: rtl/blink_dec_pkg.sv
// Shared types and constants for the blink period decoder.
//   state_e       decoder FSM states
//   SYNC_STAGES   synchronizer depth on blink_in
//   FILT_LEN      consecutive cycles a new level must persist when the glitch filter is built in
//   onehot_index  8-bit value -> {valid, bit index}; valid only for exactly one bit set
package blink_dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StLocked
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_LEN    = 3;

  function automatic logic [3:0] onehot_index(input logic [7:0] v);
    logic [3:0] r;
    r = '0;
    if (v != 8'd0 && (v & (v - 8'd1)) == 8'd0) begin
      r[3] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) r[2:0] = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/blink_edge_detect.sv
// Input conditioning for the blink decoder: synchronizer, optional glitch filter, level
// register and a single-cycle edge pulse.
//   clk, rst    clock, asynchronous active-high reset
//   blink_in    raw asynchronous blink waveform
//   level       conditioned input level
//   edge_pulse  high for one cycle when level is about to change
// Build option: BLINK_DEC_GLITCH_FILTER_EN makes the level follow the synchronized input only
// after it has differed for FILT_LEN consecutive cycles.
module blink_edge_detect
  import blink_dec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic blink_in,
  output logic level,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   level_q;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign level    = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], blink_in};
    end
  end

`ifdef BLINK_DEC_GLITCH_FILTER_EN
  localparam int unsigned FiltW = $clog2(FILT_LEN);

  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             differ;

  always_comb begin
    differ     = sync_out != level_q;
    // filt_cnt_q counts prior differing cycles; this cycle is the FILT_LEN-th
    edge_pulse = differ && (filt_cnt_q == FiltW'(FILT_LEN - 1));
    filt_cnt_d = (differ && !edge_pulse) ? filt_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_q <= '0;
      level_q    <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      if (edge_pulse) level_q <= sync_out;
    end
  end
`else
  always_comb begin
    edge_pulse = sync_out != level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= sync_out;
    end
  end
`endif

endmodule

// File: rtl/blink_period_decoder.sv
// Receive side of the programmable blinker: measures each blink phase in count_en ticks,
// declares lock after LOCK_CNT equal captures and decodes the shifter position of the period.
//   clk, rst     clock, asynchronous active-high reset
//   blink_in     blink waveform (asynchronous)
//   count_en     tick enable
//   half_period  last captured phase length in ticks
//   meas_valid   one-cycle pulse when half_period updates
//   locked       LOCK_CNT consecutive equal captures
//   shift_pos    bit index of one-hot (half_period - LOAD_OFFSET)
//   pos_valid    (half_period - LOAD_OFFSET) is one-hot within 8 bits
//   timeout      one-cycle pulse when no edge arrives before the counter saturates
//   blink_level  conditioned input level
// Build option: BLINK_DEC_GLITCH_FILTER_EN enables the input glitch filter.
module blink_period_decoder
  import blink_dec_pkg::*;
#(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned LOAD_OFFSET = 1,
  parameter int unsigned LOCK_CNT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  input  logic             count_en,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic [2:0]       shift_pos,
  output logic             pos_valid,
  output logic             timeout,
  output logic             blink_level
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [2:0]       match_q, match_d;
  logic             meas_q, meas_d;
  logic             tout_q, tout_d;
  logic             pos_valid_q, pos_valid_d;
  logic [2:0]       shift_q, shift_d;
  logic             edge_pulse;
  logic             cnt_sat;
  logic [31:0]      dec_val;
  logic [3:0]       oh;

  blink_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (blink_in),
    .level      (blink_level),
    .edge_pulse (edge_pulse)
  );

  assign cnt_sat = cnt_q == CntMax;

  // Tick counter restarts on every edge, counting the edge cycle itself when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_pulse) begin
      cnt_d = count_en ? CNT_W'(1) : '0;
    end else if (count_en && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    match_d = match_q;
    meas_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // First edge only establishes phase alignment.
        if (edge_pulse) state_d = StMeasure;
      end
      StMeasure, StLocked: begin
        // An edge takes priority over saturation so the saturated length is still captured.
        if (edge_pulse) begin
          half_d = cnt_q;
          meas_d = 1'b1;
          if (cnt_q == half_q) begin
            match_d = (match_q == 3'd7) ? match_q : match_q + 3'd1;
          end else begin
            match_d = 3'd1;
          end
          state_d = (32'(match_d) >= LOCK_CNT) ? StLocked : StMeasure;
        end else if (cnt_sat) begin
          tout_d  = 1'b1;
          state_d = StIdle;
          half_d  = '0;
          match_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode from the next half_period so the result is registered alongside it.
  always_comb begin
    dec_val = 32'(half_d) - 32'(LOAD_OFFSET);
    oh      = '0;
    if (32'(half_d) >= LOAD_OFFSET && dec_val < 32'd256) begin
      oh = onehot_index(dec_val[7:0]);
    end
    pos_valid_d = oh[3];
    shift_d     = oh[3] ? oh[2:0] : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      half_q      <= '0;
      match_q     <= '0;
      meas_q      <= 1'b0;
      tout_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      match_q     <= match_d;
      meas_q      <= meas_d;
      tout_q      <= tout_d;
      pos_valid_q <= pos_valid_d;
      shift_q     <= shift_d;
    end
  end

  assign half_period = half_q;
  assign meas_valid  = meas_q;
  assign locked      = state_q == StLocked;
  assign shift_pos   = shift_q;
  assign pos_valid   = pos_valid_q;
  assign timeout     = tout_q;

endmodule

// File: tb/tb_blink_period_decoder.sv
// Bench for blink_period_decoder: a default instance and a CNT_W=4 instance for timeout,
// both checked every cycle against a phase-length reference model.
module tb_blink_period_decoder;

  localparam int unsigned LOCK_CNT    = 2;
  localparam int unsigned LOAD_OFFSET = 1;
`ifdef BLINK_DEC_GLITCH_FILTER_EN
  localparam int FILT = 3;
`else
  localparam int FILT = 1;
`endif
  localparam int HIST = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b0 = 1'b0, ce0 = 1'b0, b4 = 1'b0, ce4 = 1'b0;

  logic [9:0] half_period;
  logic       meas_valid, locked, pos_valid, timeout, blink_level;
  logic [2:0] shift_pos;
  logic [3:0] half4;
  logic       meas4, locked4, pos_valid4, timeout4, level4;
  logic [2:0] shift4;

  always #5 clk = ~clk;

  blink_period_decoder #(.CNT_W(10), .LOAD_OFFSET(LOAD_OFFSET), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .blink_in(b0), .count_en(ce0), .half_period(half_period),
    .meas_valid(meas_valid), .locked(locked), .shift_pos(shift_pos), .pos_valid(pos_valid),
    .timeout(timeout), .blink_level(blink_level)
  );

  blink_period_decoder #(.CNT_W(4), .LOAD_OFFSET(LOAD_OFFSET), .LOCK_CNT(LOCK_CNT)) dut4 (
    .clk(clk), .rst(rst), .blink_in(b4), .count_en(ce4), .half_period(half4),
    .meas_valid(meas4), .locked(locked4), .shift_pos(shift4), .pos_valid(pos_valid4),
    .timeout(timeout4), .blink_level(level4)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted input levels, edge arrival times, tick totals between edges.
  int cyc = 0;
  bit edge_at  [2][HIST];
  bit edge_val [2][HIST];
  int acc [2], half_m [2], run [2], diff_run [2];
  bit first [2], acc_lvl [2], lvl_m [2], e_meas [2], e_to [2];
  int maxc [2] = '{1023, 15};

  int   meas_cnt = 0, meas4_cnt = 0, to4_cnt = 0;
  logic [9:0] snap_half;
  logic       snap_locked, snap_pv;
  logic [2:0] snap_shift;

  function automatic int dec_exp(input int unsigned h);
    int unsigned d;
    if (h < LOAD_OFFSET) return -1;
    d = h - LOAD_OFFSET;
    if (d == 0 || d >= 256 || (d & (d - 1)) != 0) return -1;
    return $clog2(d);
  endfunction

  task automatic model_reset(input int i);
    acc_lvl[i] = 0; diff_run[i] = 0; first[i] = 1; run[i] = 0; half_m[i] = 0;
    acc[i] = 0; lvl_m[i] = 0; e_meas[i] = 0; e_to[i] = 0;
    for (int k = 0; k < 4; k++) edge_at[i][cyc + k] = 0;
  endtask

  task automatic model_sample(input int i);
    bit x, ce;
    int ticks;
    x = (i == 0) ? b0 : b4;
    ce = (i == 0) ? ce0 : ce4;
    e_meas[i] = 0;
    e_to[i] = 0;
    if (rst) begin
      model_reset(i);
      return;
    end
    // A new level counts once it has been seen FILT samples in a row; the decoder acts on it
    // two cycles later (synchronizer).
    if (x != acc_lvl[i]) begin
      diff_run[i]++;
      if (diff_run[i] == FILT) begin
        acc_lvl[i] = x;
        diff_run[i] = 0;
        edge_at[i][cyc + 2] = 1;
        edge_val[i][cyc + 2] = x;
      end
    end else begin
      diff_run[i] = 0;
    end
    ticks = acc[i];
    if (edge_at[i][cyc]) begin
      edge_at[i][cyc] = 0;
      if (first[i]) begin
        first[i] = 0;
      end else begin
        run[i] = (ticks == half_m[i]) ? ((run[i] < 7) ? run[i] + 1 : 7) : 1;
        half_m[i] = ticks;
        e_meas[i] = 1;
      end
      lvl_m[i] = edge_val[i][cyc];
      acc[i] = int'(ce);
    end else begin
      if (!first[i] && ticks == maxc[i]) begin
        e_to[i] = 1; first[i] = 1; run[i] = 0; half_m[i] = 0;
      end
      acc[i] = (acc[i] + int'(ce) > maxc[i]) ? maxc[i] : acc[i] + int'(ce);
    end
  endtask

  task automatic step();
    int k0, k4;
    if (cyc + 4 >= HIST) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, HIST - 4);
      $fatal(1, "cycle budget exhausted");
    end
    model_sample(0);
    model_sample(1);
    @(posedge clk);
    #1;
    k0 = dec_exp(half_m[0]);
    k4 = dec_exp(half_m[1]);
    chk("m.meas", 32'(meas_valid), 32'(e_meas[0]));
    chk("m.timeout", 32'(timeout), 32'(e_to[0]));
    chk("m.half", 32'(half_period), half_m[0]);
    chk("m.locked", 32'(locked), (run[0] >= LOCK_CNT) ? 1 : 0);
    chk("m.pos_valid", 32'(pos_valid), (k0 >= 0) ? 1 : 0);
    chk("m.shift", 32'(shift_pos), (k0 >= 0) ? k0 : 0);
    chk("m.level", 32'(blink_level), 32'(lvl_m[0]));
    chk("s.meas", 32'(meas4), 32'(e_meas[1]));
    chk("s.timeout", 32'(timeout4), 32'(e_to[1]));
    chk("s.half", 32'(half4), half_m[1]);
    chk("s.locked", 32'(locked4), (run[1] >= LOCK_CNT) ? 1 : 0);
    chk("s.pos_valid", 32'(pos_valid4), (k4 >= 0) ? 1 : 0);
    chk("s.shift", 32'(shift4), (k4 >= 0) ? k4 : 0);
    chk("s.level", 32'(level4), 32'(lvl_m[1]));
    if (meas_valid === 1'b1) begin
      meas_cnt++;
      snap_half = half_period; snap_locked = locked;
      snap_shift = shift_pos; snap_pv = pos_valid;
    end
    if (meas4 === 1'b1) meas4_cnt++;
    if (timeout4 === 1'b1) to4_cnt++;
    cyc++;
  endtask

  // mode 0: count_en=1, 1: alternating, 2: random
  task automatic phase0(input int len, input int mode);
    b0 = ~b0;
    for (int k = 0; k < len; k++) begin
      ce0 = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic phase4(input int len);
    b4 = ~b4;
    ce4 = 1'b1;
    repeat (len) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".half"}, 32'(half_period), 0);
    chk({tag, ".meas"}, 32'(meas_valid), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".shift"}, 32'(shift_pos), 0);
    chk({tag, ".pos_valid"}, 32'(pos_valid), 0);
    chk({tag, ".timeout"}, 32'(timeout), 0);
    chk({tag, ".level"}, 32'(blink_level), 0);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("reset");
    chk("reset.s.half", 32'(half4), 0);
    chk("reset.s.locked", 32'(locked4), 0);
    ce0 = 1'b1;
    ce4 = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    // Half period 5, count_en=1.
    meas_cnt = 0;
    repeat (4) phase0(5, 0);
    chk("p5.meas_count", meas_cnt, 3);
    chk("p5.half", 32'(half_period), 5);
    chk("p5.locked", 32'(locked), 1);
    chk("p5.shift", 32'(shift_pos), 2);
    chk("p5.pos_valid", 32'(pos_valid), 1);

    // Half period 7: locks, but 6 is not one-hot.
    repeat (5) phase0(7, 0);
    chk("p7.half", 32'(half_period), 7);
    chk("p7.locked", 32'(locked), 1);
    chk("p7.pos_valid", 32'(pos_valid), 0);

    // 10-clk phases with count_en alternating -> 5 ticks.
    repeat (5) phase0(10, 1);
    chk("alt.half", 32'(half_period), 5);
    chk("alt.locked", 32'(locked), 1);

    // Switch 5 -> 9.
    repeat (2) phase0(5, 0);
    phase0(9, 0);
    phase0(9, 0);
    chk("p9a.locked", 32'(snap_locked), 0);
    chk("p9a.half", 32'(snap_half), 9);
    phase0(9, 0);
    chk("p9b.locked", 32'(snap_locked), 1);
    chk("p9b.shift", 32'(snap_shift), 3);
    chk("p9b.pos_valid", 32'(snap_pv), 1);

    // 1-clk glitch inside a 9-clk high phase.
    if (b0) phase0(9, 0);
    ce0 = 1'b1;
    b0 = 1'b1; repeat (4) step();
    b0 = 1'b0; step();
    b0 = 1'b1; repeat (4) step();
    phase0(9, 0);
`ifdef BLINK_DEC_GLITCH_FILTER_EN
    chk("glitch.half", 32'(half_period), 9);
    chk("glitch.locked", 32'(locked), 1);
`else
    chk("glitch.half", 32'(half_period), 4);
    chk("glitch.locked", 32'(locked), 0);
`endif

    // Reset mid-phase with blink_in high, then relock.
    phase0(3, 0);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    repeat (2) phase0(5, 0);
    chk("relock.locked", 32'(locked), 1);
    chk("relock.half", 32'(half_period), 5);

    // Randomized phases.
    for (int g = 0; g < 30; g++) begin
      int len, reps, mode;
      len = $urandom_range(3, 16);
      reps = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      repeat (reps) phase0(len, mode);
    end

    // Timeout on the narrow instance.
    ce0 = 1'b1;
    repeat (4) phase4(5);
    chk("s.lock_before_to", 32'(locked4), 1);
    chk("s.half_before_to", 32'(half4), 5);
    to4_cnt = 0;
    repeat (25) step();
    chk("s.timeout_count", to4_cnt, 1);
    chk("s.locked_after_to", 32'(locked4), 0);
    chk("s.half_after_to", 32'(half4), 0);
    meas4_cnt = 0;
    phase4(8);
    chk("s.first_edge_meas", meas4_cnt, 0);
    phase4(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
